// File: rtl/adders_pkg.sv
// Shared definitions for the adder family: FSM state encoding used by the serial adders.
package adders_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/fa_st.sv
// Single-bit full adder; the only combinational datapath of the serial adder.
module fa_st (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_st.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one full adder,
// the carry is held in a flop and the sum is assembled in a shift register.
module serial_adder_st
    import adders_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_sum;
    logic             fa_cout;

    fa_st u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                // Counter parks at zero on the last bit so it never exceeds WIDTH-1.
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign start_ready = (state_q == ST_IDLE);
    assign done_valid  = (state_q == ST_DONE);
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign sum_out     = sum_q;
    assign cout_out    = carry_q;

endmodule

// File: tb/tb_serial_adder_st.sv
// Directed and random checks of serial_adder_st at WIDTH=8 and WIDTH=16.
module tb_serial_adder_st;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH = 8 instance
    logic       rst8, sv8, sr8, cin8, cout8, dv8, dr8, busy8;
    logic [7:0] a8, b8, sum8;

    // WIDTH = 16 instance
    logic        rst16, sv16, sr16, cin16, cout16, dv16, dr16, busy16;
    logic [15:0] a16, b16, sum16;

    serial_adder_st #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst8),
        .start_valid (sv8),
        .start_ready (sr8),
        .a_in        (a8),
        .b_in        (b8),
        .cin_in      (cin8),
        .sum_out     (sum8),
        .cout_out    (cout8),
        .done_valid  (dv8),
        .done_ready  (dr8),
        .busy        (busy8)
    );

    serial_adder_st #(.WIDTH(16)) dut16 (
        .clk         (clk),
        .rst         (rst16),
        .start_valid (sv16),
        .start_ready (sr16),
        .a_in        (a16),
        .b_in        (b16),
        .cin_in      (cin16),
        .sum_out     (sum16),
        .cout_out    (cout16),
        .done_valid  (dv16),
        .done_ready  (dr16),
        .busy        (busy16)
    );

    // Drive one start handshake on the 8-bit DUT (must be in IDLE).
    task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic c);
        sv8  = 1'b1;
        a8   = a;
        b8   = b;
        cin8 = c;
        @(posedge clk); #1;
        sv8 = 1'b0;
    endtask

    // Count edges after acceptance until done_valid, bounded by budget.
    task automatic wait_done8(input int budget, output int cycles);
        cycles = 0;
        while (dv8 !== 1'b1 && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic release8();
        dr8 = 1'b1;
        @(posedge clk); #1;
        dr8 = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({sr8, dv8, busy8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset8: got sr=%b dv=%b busy=%b cout=%b sum=%h, need 1 0 0 0 00",
                     sr8, dv8, busy8, cout8, sum8);
        end
        rst8 = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        accept8(8'h0F, 8'h01, 1'b0);
        checks++;
        if (busy8 !== 1'b1 || sr8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: got busy=%b sr=%b, need 1 0", busy8, sr8);
        end
        wait_done8(20, n);
        checks++;
        if (n != 8 || dv8 !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles (dv=%b), need 8", n, dv8);
        end
        checks++;
        if ({cout8, sum8} !== 9'h010) begin
            errors++;
            $display("FAIL basic_sum: got cout=%b sum=%h, need 0 10", cout8, sum8);
        end
        release8();
        checks++;
        if (sr8 !== 1'b1 || dv8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_exit: got sr=%b dv=%b busy=%b, need 1 0 0", sr8, dv8, busy8);
        end
    endtask

    task automatic test_carry();
        int n;
        accept8(8'hFF, 8'h01, 1'b0);
        wait_done8(20, n);
        checks++;
        if (dv8 !== 1'b1 || {cout8, sum8} !== 9'h100) begin
            errors++;
            $display("FAIL carry_ff01: got dv=%b cout=%b sum=%h, need 1 1 00", dv8, cout8, sum8);
        end
        release8();
        accept8(8'hFF, 8'hFF, 1'b1);
        wait_done8(20, n);
        checks++;
        if (dv8 !== 1'b1 || {cout8, sum8} !== 9'h1FF) begin
            errors++;
            $display("FAIL carry_ffff1: got dv=%b cout=%b sum=%h, need 1 1 ff", dv8, cout8, sum8);
        end
        release8();
    endtask

    task automatic test_backpressure();
        int n;
        accept8(8'h5A, 8'h33, 1'b0);
        wait_done8(20, n);
        for (int i = 0; i < 5; i++) begin
            sv8  = i[0] ? 1'b0 : 1'b1;
            a8   = 8'hFF;
            b8   = 8'hFF;
            cin8 = 1'b1;
            @(posedge clk); #1;
            checks++;
            if ({dv8, sr8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 8'h8D}) begin
                errors++;
                $display("FAIL backpressure[%0d]: got dv=%b sr=%b cout=%b sum=%h, need 1 0 0 8d",
                         i, dv8, sr8, cout8, sum8);
            end
        end
        sv8 = 1'b0;
        release8();
        @(posedge clk); #1;
        checks++;
        if (busy8 !== 1'b0 || sr8 !== 1'b1 || sum8 !== 8'h8D) begin
            errors++;
            $display("FAIL backpressure_exit: got busy=%b sr=%b sum=%h, need 0 1 8d",
                     busy8, sr8, sum8);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int seen;
        accept8(8'hAA, 8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst8 = 1'b1;
        #1;
        checks++;
        if ({sr8, dv8, busy8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL midrun_reset: got sr=%b dv=%b busy=%b cout=%b sum=%h, need 1 0 0 0 00",
                     sr8, dv8, busy8, cout8, sum8);
        end
        @(posedge clk); #1;
        rst8 = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (dv8 !== 1'b0 || busy8 !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrun_no_done: got %0d active cycles after abort, need 0", seen);
        end
        accept8(8'h12, 8'h34, 1'b0);
        wait_done8(20, n);
        checks++;
        if (dv8 !== 1'b1 || {cout8, sum8} !== 9'h046) begin
            errors++;
            $display("FAIL midrun_next: got dv=%b cout=%b sum=%h, need 1 0 46", dv8, cout8, sum8);
        end
        release8();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta [4] = '{8'h3C, 8'h80, 8'h7F, 8'h12};
        logic [7:0] tb [4] = '{8'hC3, 8'h80, 8'h01, 8'h34};
        logic       tc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [8:0] te [4] = '{9'h100, 9'h100, 9'h080, 9'h047};
        int n;
        dr8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sr8 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got sr=%b, need 1", k, sr8);
            end
            sv8  = 1'b1;
            a8   = ta[k];
            b8   = tb[k];
            cin8 = tc[k];
            @(posedge clk); #1;
            checks++;
            if (busy8 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_accept[%0d]: got busy=%b, need 1", k, busy8);
            end
            n = 0;
            while (dv8 !== 1'b1 && n < 20) begin
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                cin8 = ~cin8;
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (n != 8 || {cout8, sum8} !== te[k]) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got %0d cycles cout=%b sum=%h, need 8 %b %h",
                         k, n, cout8, sum8, te[k][8], te[k][7:0]);
            end
            @(posedge clk); #1;
        end
        sv8 = 1'b0;
        dr8 = 1'b0;
    endtask

    task automatic test_random16();
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] exp;
        int          n;
        rst16 = 1'b1;
        #1;
        checks++;
        if ({sr16, dv16, busy16, cout16, sum16} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset16: got sr=%b dv=%b busy=%b cout=%b sum=%h, need 1 0 0 0 0000",
                     sr16, dv16, busy16, cout16, sum16);
        end
        @(posedge clk); #1;
        rst16 = 1'b0;
        for (int k = 0; k < 200; k++) begin
            ra    = 16'($urandom);
            rb    = 16'($urandom);
            rc    = 1'($urandom);
            exp   = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            sv16  = 1'b1;
            a16   = ra;
            b16   = rb;
            cin16 = rc;
            @(posedge clk); #1;
            sv16 = 1'b0;
            n = 0;
            while (dv16 !== 1'b1 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (n != 16 || {cout16, sum16} !== exp) begin
                errors++;
                $display("FAIL rand16[%0d]: %h+%h+%b got %0d cycles %h, need 16 %h",
                         k, ra, rb, rc, n, {cout16, sum16}, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst8  = 1'b1;
        rst16 = 1'b1;
        sv8   = 1'b0;
        sv16  = 1'b0;
        dr8   = 1'b0;
        dr16  = 1'b1;
        a8    = '0;
        b8    = '0;
        cin8  = 1'b0;
        a16   = '0;
        b16   = '0;
        cin16 = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
